ntsc_timing_gen: RTL and testbench
==================================

Name: ntsc_timing_gen

Overview:
- Sequences the 4-bit video DAC for monochrome, non-interlaced 262-line NTSC.
- Runs in the 16 MHz clk domain, released by the reset controller once the PLL locks.
- Generates horizontal and vertical timing, requests pixels from a registered pixel source, and drives sync, blank or clamped pixel levels onto vdac.

Parameters:
- LINE_CYCLES, 1016, clk cycles per line (63.5 us at 16 MHz).
- HSYNC_CYCLES, 75, horizontal sync width.
- BP_CYCLES, 93, back porch width.
- ACTIVE_CYCLES, 824, active pixels per line. Front porch = LINE_CYCLES - HSYNC_CYCLES - BP_CYCLES - ACTIVE_CYCLES = 24.
- LINES, 262, lines per field.
- VSYNC_START, 3, first vertical sync line.
- VSYNC_LINES, 3, number of vertical sync lines.
- VBLANK_LINES, 20, lines 0..VBLANK_LINES-1 are blanked. Active lines are 20..261 (242 lines).
- SYNC_LEVEL, 0, DAC code for sync tip.
- BLANK_LEVEL, 5, DAC code for blanking.
- BLACK_LEVEL, 6, minimum DAC code during active video.

Ports:
- clk  input  1  system clock, 16 MHz, global buffer.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run timing when high.
- pix_req  output  1  pixel request for (pix_x, pix_y).
- pix_x  output  10  active pixel column, 0..ACTIVE_CYCLES-1.
- pix_y  output  9  active line index, 0..LINES-VBLANK_LINES-1.
- pix_data  input  4  pixel value, returned one cycle after pix_req.
- vdac_out  output  4  DAC code.
- hsync  output  1  high during sync tip, aligned with vdac_out.
- vsync  output  1  high on vertical sync lines, aligned with vdac_out.
- line_start  output  1  one-cycle pulse at h=0, aligned with vdac_out.
- frame_start  output  1  one-cycle pulse at h=0, v=0, aligned with vdac_out.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset; all registers initialise on the clk edge where reset=1.
- Reset values: h=0, v=0, vdac_out=BLANK_LEVEL, pix_req=0, pix_x=0, pix_y=0, hsync=0, vsync=0, line_start=0, frame_start=0. Reset mid-line discards pipeline contents; the first output after release is the h=0, v=0 stage.
- Stage 0 (counters):
  - h runs 0..LINE_CYCLES-1 and wraps to 0. On wrap, v increments; v wraps from LINES-1 to 0.
  - Horizontal state machine is derived from h: HSYNC for h<HSYNC_CYCLES; BACK_PORCH until HSYNC_CYCLES+BP_CYCLES; ACTIVE for the next ACTIVE_CYCLES; FRONT_PORCH for the remainder.
  - Vertical state per line: VBLANK, VSYNC or VACTIVE. VSYNC covers v in [VSYNC_START, VSYNC_START+VSYNC_LINES); it overrides VBLANK.
- Level selection (decided in stage 0):
  - VSYNC line: SYNC_LEVEL for h < LINE_CYCLES-HSYNC_CYCLES, then BLANK_LEVEL (inverted sync).
  - Any other line in HSYNC: SYNC_LEVEL.
  - VBLANK line outside HSYNC: BLANK_LEVEL.
  - VACTIVE line: BLANK_LEVEL in porches; pixel in ACTIVE.
- Pixel handshake:
  - pix_req is high in stage 0 for every ACTIVE cycle of a VACTIVE line, with pix_x = h-HSYNC_CYCLES-BP_CYCLES and pix_y = v-VBLANK_LINES.
  - pix_data is sampled exactly one cycle later, with no backpressure.
  - Pixel output is max(pix_data, BLACK_LEVEL); codes 6..15 pass unchanged, 0..5 become 6.
- Latency: every stage-0 decision appears on vdac_out/hsync/vsync/line_start/frame_start exactly 2 cycles later. pix_req leads its pixel on vdac_out by 2 cycles.
- enable low: counters are held at h=0, v=0; pipeline flushes to BLANK_LEVEL with hsync=vsync=0 and no pulses; pix_req=0. Rising enable starts at h=0, v=0, and frame_start appears 2 cycles later.
- Simultaneous reset and enable: reset wins.
- Width rules: h is 10 bits and v is 9 bits. Counter widths are sized from the parameters; wrap comparisons use LINE_CYCLES-1 and LINES-1 exactly, with no overflow.

Test Plan:
- Reset asserted 3 cycles, then enable=1 -> vdac_out=5 through release; frame_start at release+2 cycles; vdac_out=0 for 941 cycles from that point (VSYNC line? no, line 0 is VBLANK: 75 cycles of 0, then 941 cycles of 5).
- Run to line 3 -> vdac_out=0 for 941 cycles, then 5 for 75 cycles; vsync=1 for the whole line; repeats on lines 4 and 5; line 6 returns to normal hsync.
- Line 20, pixel source returns pix_x[3:0] -> first pix_req at h=168 with pix_x=0, pix_y=0; vdac_out at h=170 equals max(0,6)=6; pix_x=10 gives 10; exactly 824 requests on the line.
- Full frame count -> line_start every 1016 cycles; frame_start every 266192 cycles; pix_y reaches 241 and then pix_req stays low until the next frame.
- enable dropped mid-active at v=100 -> within 2 cycles vdac_out=5 and pix_req=0; re-enable gives frame_start 2 cycles later at v=0.
- reset pulsed for 1 cycle at h=500, v=150 -> next outputs return to the reset values; timing restarts at h=0, v=0 with no stale pixels on vdac_out.

Source files
------------

// File: rtl/ntsc_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ntsc_timing_gen
//  Purpose  : Monochrome, non-interlaced 262-line NTSC timing generator.
//             Sequences a 4-bit video DAC with sync, blanking and clamped
//             pixel levels. Requests pixels from a registered pixel source.
//  Revision : 1.0  initial release
// ============================================================================
module ntsc_timing_gen #(
    parameter int LINE_CYCLES   = 1016,
    parameter int HSYNC_CYCLES  = 75,
    parameter int BP_CYCLES     = 93,
    parameter int ACTIVE_CYCLES = 824,
    parameter int LINES         = 262,
    parameter int VSYNC_START   = 3,
    parameter int VSYNC_LINES   = 3,
    parameter int VBLANK_LINES  = 20,
    parameter int SYNC_LEVEL    = 0,
    parameter int BLANK_LEVEL   = 5,
    parameter int BLACK_LEVEL   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       pix_req,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    input  logic [3:0] pix_data,
    output logic [3:0] vdac_out,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    // Counter widths cover the full parameter value so boundary constants
    // (e.g. an end-of-active equal to LINE_CYCLES) never overflow.
    localparam int c_H_W = $clog2(LINE_CYCLES + 1);
    localparam int c_V_W = $clog2(LINES + 1);

    localparam logic [c_H_W-1:0] c_H_ONE       = c_H_W'(1);
    localparam logic [c_H_W-1:0] c_H_LAST      = c_H_W'(LINE_CYCLES - 1);
    localparam logic [c_H_W-1:0] c_H_SYNC_END  = c_H_W'(HSYNC_CYCLES);
    localparam logic [c_H_W-1:0] c_H_ACT_START = c_H_W'(HSYNC_CYCLES + BP_CYCLES);
    localparam logic [c_H_W-1:0] c_H_ACT_END   = c_H_W'(HSYNC_CYCLES + BP_CYCLES + ACTIVE_CYCLES);
    // On vertical sync lines the sync is inverted: long tip, short blank.
    localparam logic [c_H_W-1:0] c_H_VSYNC_END = c_H_W'(LINE_CYCLES - HSYNC_CYCLES);

    localparam logic [c_V_W-1:0] c_V_ONE        = c_V_W'(1);
    localparam logic [c_V_W-1:0] c_V_LAST       = c_V_W'(LINES - 1);
    localparam logic [c_V_W-1:0] c_V_SYNC_START = c_V_W'(VSYNC_START);
    localparam logic [c_V_W-1:0] c_V_SYNC_END   = c_V_W'(VSYNC_START + VSYNC_LINES);
    localparam logic [c_V_W-1:0] c_V_ACT_START  = c_V_W'(VBLANK_LINES);

    localparam logic [3:0] c_SYNC  = 4'(SYNC_LEVEL);
    localparam logic [3:0] c_BLANK = 4'(BLANK_LEVEL);
    localparam logic [3:0] c_BLACK = 4'(BLACK_LEVEL);

    typedef enum logic [1:0] {
        H_SYNC        = 2'd0,
        H_BACK_PORCH  = 2'd1,
        H_ACTIVE      = 2'd2,
        H_FRONT_PORCH = 2'd3
    } hstate_t;

    typedef enum logic [1:0] {
        V_BLANK  = 2'd0,
        V_SYNC   = 2'd1,
        V_ACTIVE = 2'd2
    } vstate_t;

    logic [c_H_W-1:0] r_h;
    logic [c_V_W-1:0] r_v;

    hstate_t    w_hstate;
    vstate_t    w_vstate;
    logic [3:0] w_level;
    logic       w_sync;
    logic       w_pix_sel;
    logic       w_vsync;
    logic       w_line_start;
    logic       w_frame_start;
    logic [3:0] w_pix_clamped;

    logic [3:0] r_s1_level;
    logic       r_s1_pix_sel;
    logic       r_s1_hsync;
    logic       r_s1_vsync;
    logic       r_s1_line_start;
    logic       r_s1_frame_start;

    // Stage 0: line/field counters; held at the origin while disabled.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == c_H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == c_V_LAST) ? '0 : r_v + c_V_ONE;
        end else begin
            r_h <= r_h + c_H_ONE;
        end
    end

    // Horizontal region decoded from the pixel counter.
    always_comb begin
        w_hstate = H_FRONT_PORCH;
        if (r_h < c_H_SYNC_END) begin
            w_hstate = H_SYNC;
        end else if (r_h < c_H_ACT_START) begin
            w_hstate = H_BACK_PORCH;
        end else if (r_h < c_H_ACT_END) begin
            w_hstate = H_ACTIVE;
        end
    end

    // Vertical region per line; sync lines take priority over blanking.
    always_comb begin
        w_vstate = V_ACTIVE;
        if (r_v >= c_V_SYNC_START && r_v < c_V_SYNC_END) begin
            w_vstate = V_SYNC;
        end else if (r_v < c_V_ACT_START) begin
            w_vstate = V_BLANK;
        end
    end

    // Stage 0 level decision; everything idles at blank while disabled.
    always_comb begin
        w_level   = c_BLANK;
        w_sync    = 1'b0;
        w_pix_sel = 1'b0;
        if (enable) begin
            case (w_vstate)
                V_SYNC: begin
                    if (r_h < c_H_VSYNC_END) begin
                        w_level = c_SYNC;
                        w_sync  = 1'b1;
                    end
                end
                V_BLANK: begin
                    if (w_hstate == H_SYNC) begin
                        w_level = c_SYNC;
                        w_sync  = 1'b1;
                    end
                end
                default: begin
                    if (w_hstate == H_SYNC) begin
                        w_level = c_SYNC;
                        w_sync  = 1'b1;
                    end else if (w_hstate == H_ACTIVE) begin
                        w_pix_sel = 1'b1;
                    end
                end
            endcase
        end
    end

    assign w_vsync       = enable && (w_vstate == V_SYNC);
    assign w_line_start  = enable && (r_h == '0);
    assign w_frame_start = w_line_start && (r_v == '0);

    // Pixel request is issued in stage 0 so the registered source answers
    // in stage 1, just in time for the output register.
    assign pix_req = w_pix_sel;
    assign pix_x   = w_pix_sel ? 10'(r_h - c_H_ACT_START) : 10'd0;
    assign pix_y   = w_pix_sel ? 9'(r_v - c_V_ACT_START) : 9'd0;

    // Active video never dips below black, keeping it clear of sync/blank.
    assign w_pix_clamped = (pix_data < c_BLACK) ? c_BLACK : pix_data;

    // Stage 1: hold the stage-0 decision while the pixel is fetched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_level       <= c_BLANK;
            r_s1_pix_sel     <= 1'b0;
            r_s1_hsync       <= 1'b0;
            r_s1_vsync       <= 1'b0;
            r_s1_line_start  <= 1'b0;
            r_s1_frame_start <= 1'b0;
        end else begin
            r_s1_level       <= w_level;
            r_s1_pix_sel     <= w_pix_sel;
            r_s1_hsync       <= w_sync;
            r_s1_vsync       <= w_vsync;
            r_s1_line_start  <= w_line_start;
            r_s1_frame_start <= w_frame_start;
        end
    end

    // Stage 2: output register, merging the returned pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            vdac_out    <= c_BLANK;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vdac_out    <= r_s1_pix_sel ? w_pix_clamped : r_s1_level;
            hsync       <= r_s1_hsync;
            vsync       <= r_s1_vsync;
            line_start  <= r_s1_line_start;
            frame_start <= r_s1_frame_start;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntsc_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntsc_timing_gen
//  Purpose  : Directed, table-driven bench for ntsc_timing_gen. Uses a short
//             24-line field so a full field plus wrap fits in a short run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ntsc_timing_gen;

    localparam int L  = 1016;
    localparam int NL = 24;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pix_req;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [3:0] pix_data;
    logic [3:0] vdac_out;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;

    ntsc_timing_gen #(
        .LINES (NL)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .vdac_out    (vdac_out),
        .hsync       (hsync),
        .vsync       (vsync),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Registered pixel source: returns the low nibble of the requested column.
    always_ff @(posedge clk) pix_data <= pix_x[3:0];

    typedef struct {
        int         n;
        logic       req;
        logic [9:0] x;
        logic [8:0] y;
        logic [3:0] vdac;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } vec_t;

    vec_t vec [32];
    int   nv = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic add(input int n, input logic req, input int x, input int y,
                       input int vdac, input logic hs, input logic vs,
                       input logic ls, input logic fs);
        vec[nv] = '{n, req, 10'(x), 9'(y), 4'(vdac), hs, vs, ls, fs};
        nv++;
    endtask

    task automatic chk(input string name, input int n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @stage %0d: got %0d expected %0d", name, n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input int n, input int vd, input logic hs,
                           input logic vs, input logic ls, input logic fs);
        chk({tag, "_vdac"}, n, 32'(vdac_out), 32'(vd));
        chk({tag, "_hsync"}, n, 32'(hsync), 32'(hs));
        chk({tag, "_vsync"}, n, 32'(vsync), 32'(vs));
        chk({tag, "_line_start"}, n, 32'(line_start), 32'(ls));
        chk({tag, "_frame_start"}, n, 32'(frame_start), 32'(fs));
    endtask

    // Time limit: the run needs roughly 66k cycles.
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int ip = 0;
        int io = 0;
        int nmax;
        int req_frame = 0;
        int req_line20 = 0;
        int ls_cnt = 0;
        int fs_cnt = 0;
        int base;

        reset  = 1'b1;
        enable = 1'b1;

        //   stage          req x    y  vdac hs vs ls fs
        add(0,              0,  0,   0, 0,   1, 0, 1, 1);
        add(74,             0,  0,   0, 0,   1, 0, 0, 0);
        add(75,             0,  0,   0, 5,   0, 0, 0, 0);
        add(1015,           0,  0,   0, 5,   0, 0, 0, 0);
        add(L,              0,  0,   0, 0,   1, 0, 1, 0);
        add(3*L,            0,  0,   0, 0,   1, 1, 1, 0);
        add(3*L+940,        0,  0,   0, 0,   1, 1, 0, 0);
        add(3*L+941,        0,  0,   0, 5,   0, 1, 0, 0);
        add(3*L+1015,       0,  0,   0, 5,   0, 1, 0, 0);
        add(5*L+500,        0,  0,   0, 0,   1, 1, 0, 0);
        add(6*L,            0,  0,   0, 0,   1, 0, 1, 0);
        add(6*L+75,         0,  0,   0, 5,   0, 0, 0, 0);
        add(19*L+500,       0,  0,   0, 5,   0, 0, 0, 0);
        add(20*L+167,       0,  0,   0, 5,   0, 0, 0, 0);
        add(20*L+168,       1,  0,   0, 6,   0, 0, 0, 0);
        add(20*L+173,       1,  5,   0, 6,   0, 0, 0, 0);
        add(20*L+174,       1,  6,   0, 6,   0, 0, 0, 0);
        add(20*L+178,       1,  10,  0, 10,  0, 0, 0, 0);
        add(20*L+183,       1,  15,  0, 15,  0, 0, 0, 0);
        add(20*L+184,       1,  16,  0, 6,   0, 0, 0, 0);
        add(20*L+991,       1,  823, 0, 7,   0, 0, 0, 0);
        add(20*L+992,       0,  0,   0, 5,   0, 0, 0, 0);
        add(20*L+1015,      0,  0,   0, 5,   0, 0, 0, 0);
        add(21*L,           0,  0,   0, 0,   1, 0, 1, 0);
        add(23*L+168,       1,  0,   3, 6,   0, 0, 0, 0);
        add(23*L+500,       1,  332, 3, 12,  0, 0, 0, 0);
        add(24*L,           0,  0,   0, 0,   1, 0, 1, 1);
        add(24*L+500,       0,  0,   0, 5,   0, 0, 0, 0);
        nmax = vec[nv-1].n + 2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_out("reset", -1, 5, 0, 0, 0, 0);
        chk("reset_pix_req", -1, 32'(pix_req), 0);
        chk("reset_pix_x", -1, 32'(pix_x), 0);
        chk("reset_pix_y", -1, 32'(pix_y), 0);
        reset = 1'b0;
        cyc   = 0;

        // Table run: one full field and into the next.
        for (int k = 0; k <= nmax; k++) begin
            if (k > 0) step();
            if (k < 2) begin
                chk("release_vdac", k, 32'(vdac_out), 5);
                chk("release_frame_start", k, 32'(frame_start), 0);
            end
            while (ip < nv && vec[ip].n == k) begin
                chk("pix_req", k, 32'(pix_req), 32'(vec[ip].req));
                if (vec[ip].req) begin
                    chk("pix_x", k, 32'(pix_x), 32'(vec[ip].x));
                    chk("pix_y", k, 32'(pix_y), 32'(vec[ip].y));
                end
                ip++;
            end
            while (io < nv && vec[io].n + 2 == k) begin
                chk_out("vec", vec[io].n, int'(vec[io].vdac), vec[io].hs,
                        vec[io].vs, vec[io].ls, vec[io].fs);
                io++;
            end
            if (k < NL*L) req_frame += int'(pix_req);
            if (k >= 20*L && k < 21*L) req_line20 += int'(pix_req);
            if (k >= 2 && k < NL*L + 2) begin
                ls_cnt += int'(line_start);
                fs_cnt += int'(frame_start);
            end
        end
        chk("vectors_applied", cyc, 32'(io), 32'(nv));
        chk("requests_line20", 20*L, 32'(req_line20), 824);
        chk("requests_field", 0, 32'(req_frame), 32'((NL - 20) * 824));
        chk("line_starts_field", 0, 32'(ls_cnt), NL);
        chk("frame_starts_field", 0, 32'(fs_cnt), 1);

        // One-cycle reset mid-active (line 20, h=500) of the second field.
        while (cyc < (NL + 20)*L + 500) step();
        chk("rstmid_pix_req", cyc, 32'(pix_req), 1);
        chk("rstmid_pix_x", cyc, 32'(pix_x), 332);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_out("rstmid_p1", cyc, 5, 0, 0, 0, 0);
        chk("rstmid_p1_pix_req", cyc, 32'(pix_req), 0);
        base = cyc;
        step();
        chk_out("rstmid_p2", cyc, 5, 0, 0, 0, 0);
        step();
        chk_out("rstmid_p3", cyc, 0, 1, 0, 1, 1);

        // Enable dropped mid-active (line 20, h=310) after the restart.
        while (cyc < base + 20*L + 310) step();
        chk("endrop_pix_req", cyc, 32'(pix_req), 1);
        chk("endrop_pix_x", cyc, 32'(pix_x), 142);
        enable = 1'b0;
        #1;
        chk("endrop_req_low", cyc, 32'(pix_req), 0);
        step();
        chk("endrop_inflight_vdac", cyc, 32'(vdac_out), 13);
        step();
        chk_out("endrop_flushed", cyc, 5, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("endrop_idle_vdac", cyc, 32'(vdac_out), 5);
            chk("endrop_idle_req", cyc, 32'(pix_req), 0);
            chk("endrop_idle_fs", cyc, 32'(frame_start), 0);
        end
        enable = 1'b1;
        #1;
        chk("reen_req", cyc, 32'(pix_req), 0);
        step();
        chk_out("reen_p1", cyc, 5, 0, 0, 0, 0);
        step();
        chk_out("reen_p2", cyc, 0, 1, 0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
